// File: rtl/ifu_fetch_queue_if.sv
// Fetch-queue bundle bus: upstream enqueue side, downstream dequeue side, flush and occupancy.
// slave = the queue itself, master = whoever drives enq/deq_ready/flush.
interface ifu_fetch_queue_if #(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned INSTR_PER_FETCH = 4,
   parameter int unsigned ILEN            = 32,
   parameter int unsigned VLEN            = 32
);
   localparam int unsigned N     = INSTR_PER_FETCH;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic                flush_i;
   logic                enq_valid_i;
   logic                enq_ready_o;
   logic [VLEN-1:0]     enq_pc_i;
   logic [N*ILEN-1:0]   enq_instr_i;
   logic [N-1:0]        enq_slot_valid_i;
   logic [N-1:0]        enq_pred_taken_i;
   logic [VLEN-1:0]     enq_pred_target_i;
   logic                deq_valid_o;
   logic                deq_ready_i;
   logic [VLEN-1:0]     deq_pc_o;
   logic [N*ILEN-1:0]   deq_instr_o;
   logic [N-1:0]        deq_slot_valid_o;
   logic [N-1:0]        deq_pred_taken_o;
   logic [VLEN-1:0]     deq_pred_target_o;
   logic [CNT_W-1:0]    count_o;

   modport slave (
      input  flush_i, enq_valid_i, enq_pc_i, enq_instr_i, enq_slot_valid_i,
             enq_pred_taken_i, enq_pred_target_i, deq_ready_i,
      output enq_ready_o, deq_valid_o, deq_pc_o, deq_instr_o, deq_slot_valid_o,
             deq_pred_taken_o, deq_pred_target_o, count_o
   );

   modport master (
      output flush_i, enq_valid_i, enq_pc_i, enq_instr_i, enq_slot_valid_i,
             enq_pred_taken_i, enq_pred_target_i, deq_ready_i,
      input  enq_ready_o, deq_valid_o, deq_pc_o, deq_instr_o, deq_slot_valid_o,
             deq_pred_taken_o, deq_pred_target_o, count_o
   );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Fetch-bundle FIFO between ICache/BPU and decode; circular buffer of DEPTH entries, flushed on redirect.
// Optional macro IFU_FQ_BYPASS_EN: empty-queue bypass with 0-cycle enq->deq latency.
module ifu_fetch_queue #(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned INSTR_PER_FETCH = 4,
   parameter int unsigned ILEN            = 32,
   parameter int unsigned VLEN            = 32
) (
   input logic               clk_i,
   input logic               rst_i,
   ifu_fetch_queue_if.slave  fq
);
   localparam int unsigned N     = INSTR_PER_FETCH;
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [VLEN-1:0]   pc_q          [DEPTH];
   logic [N*ILEN-1:0] instr_q       [DEPTH];
   logic [N-1:0]      slot_valid_q  [DEPTH];
   logic [N-1:0]      pred_taken_q  [DEPTH];
   logic [VLEN-1:0]   pred_target_q [DEPTH];

   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              full_s;
   logic              empty_s;
   logic              bypass_s;
   logic              enq_ready_s;
   logic              deq_valid_s;
   logic              enq_fire_s;
   logic              deq_fire_s;
   logic              write_s;
   logic              pop_s;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   // Handshake decode: ready/valid never depend on the opposite side's ready.
   always_comb begin
      full_s      = (count_q == CNT_W'(DEPTH));
      empty_s     = (count_q == {CNT_W{1'b0}});
      enq_ready_s = ~full_s & ~fq.flush_i;
`ifdef IFU_FQ_BYPASS_EN
      bypass_s    = empty_s & ~fq.flush_i;
      deq_valid_s = bypass_s ? fq.enq_valid_i : (~empty_s & ~fq.flush_i);
`else
      bypass_s    = 1'b0;
      deq_valid_s = ~empty_s & ~fq.flush_i;
`endif
      enq_fire_s  = fq.enq_valid_i & enq_ready_s;
      deq_fire_s  = deq_valid_s & fq.deq_ready_i;
      // A bypassed bundle consumed in the same cycle never touches storage.
      write_s     = enq_fire_s & ~(bypass_s & deq_fire_s);
      pop_s       = deq_fire_s & ~bypass_s;
   end

   // Next-state for pointers and occupancy; flush overrides everything.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (fq.flush_i) begin
         head_d  = {PTR_W{1'b0}};
         tail_d  = {PTR_W{1'b0}};
         count_d = {CNT_W{1'b0}};
      end else begin
         if (write_s) begin
            tail_d = ptr_inc(tail_q);
         end else begin
            tail_d = tail_q;
         end
         if (pop_s) begin
            head_d = ptr_inc(head_q);
         end else begin
            head_d = head_q;
         end
         case ({write_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_q  <= {PTR_W{1'b0}};
         tail_q  <= {PTR_W{1'b0}};
         count_q <= {CNT_W{1'b0}};
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; data is intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (write_s) begin
         pc_q[tail_q]          <= fq.enq_pc_i;
         instr_q[tail_q]       <= fq.enq_instr_i;
         slot_valid_q[tail_q]  <= fq.enq_slot_valid_i;
         pred_taken_q[tail_q]  <= fq.enq_pred_taken_i;
         pred_target_q[tail_q] <= fq.enq_pred_target_i;
      end
   end

   // Head read and output drive.
   always_comb begin
      fq.enq_ready_o       = enq_ready_s;
      fq.deq_valid_o       = deq_valid_s;
      fq.count_o           = count_q;
      fq.deq_pc_o          = pc_q[head_q];
      fq.deq_instr_o       = instr_q[head_q];
      fq.deq_slot_valid_o  = slot_valid_q[head_q];
      fq.deq_pred_taken_o  = pred_taken_q[head_q];
      fq.deq_pred_target_o = pred_target_q[head_q];
`ifdef IFU_FQ_BYPASS_EN
      if (bypass_s) begin
         fq.deq_pc_o          = fq.enq_pc_i;
         fq.deq_instr_o       = fq.enq_instr_i;
         fq.deq_slot_valid_o  = fq.enq_slot_valid_i;
         fq.deq_pred_taken_o  = fq.enq_pred_taken_i;
         fq.deq_pred_target_o = fq.enq_pred_target_i;
      end else begin
         fq.deq_pc_o          = pc_q[head_q];
      end
`endif
   end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: a DEPTH=4 instance and a DEPTH=3 (non-power-of-two) instance.
module tb_ifu_fetch_queue;
   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   ifu_fetch_queue_if #(.DEPTH(4), .INSTR_PER_FETCH(4), .ILEN(32), .VLEN(32)) f4();
   ifu_fetch_queue_if #(.DEPTH(3), .INSTR_PER_FETCH(4), .ILEN(32), .VLEN(32)) f3();

   ifu_fetch_queue #(.DEPTH(4), .INSTR_PER_FETCH(4), .ILEN(32), .VLEN(32)) dut4 (
      .clk_i (clk), .rst_i (rst), .fq (f4)
   );
   ifu_fetch_queue #(.DEPTH(3), .INSTR_PER_FETCH(4), .ILEN(32), .VLEN(32)) dut3 (
      .clk_i (clk), .rst_i (rst), .fq (f3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      f4.flush_i = 1'b0; f4.enq_valid_i = 1'b0; f4.enq_pc_i = 32'h0;
      f4.enq_instr_i = 128'h0; f4.enq_slot_valid_i = 4'h0; f4.enq_pred_taken_i = 4'h0;
      f4.enq_pred_target_i = 32'h0; f4.deq_ready_i = 1'b0;
      f3.flush_i = 1'b0; f3.enq_valid_i = 1'b0; f3.enq_pc_i = 32'h0;
      f3.enq_instr_i = 128'h0; f3.enq_slot_valid_i = 4'h0; f3.enq_pred_taken_i = 4'h0;
      f3.enq_pred_target_i = 32'h0; f3.deq_ready_i = 1'b0;
   endtask

   task automatic push4(input logic [31:0] pc);
      f4.enq_valid_i = 1'b1;
      f4.enq_pc_i    = pc;
      tick();
      f4.enq_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      checks++; if (f4.enq_ready_o !== 1'b1) begin errors++; $display("FAIL reset_enq_ready got %b want 1", f4.enq_ready_o); end
      checks++; if (f4.deq_valid_o !== 1'b0) begin errors++; $display("FAIL reset_deq_valid got %b want 0", f4.deq_valid_o); end
      checks++; if (f4.count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", f4.count_o); end
      checks++; if (f3.count_o !== 2'd0) begin errors++; $display("FAIL reset_count3 got %0d want 0", f3.count_o); end
   endtask

   task automatic test_single();
      tick();
      f4.enq_valid_i       = 1'b1;
      f4.enq_pc_i          = 32'h8000_0000;
      f4.enq_instr_i       = {32'h193, 32'h113, 32'h93, 32'h13};
      f4.enq_slot_valid_i  = 4'b1111;
      f4.enq_pred_taken_i  = 4'b0100;
      f4.enq_pred_target_i = 32'h8000_0040;
      f4.deq_ready_i       = 1'b1;
      #1;
      checks++; if (f4.deq_valid_o !== 1'b0) begin errors++; $display("FAIL single_pre_valid got %b want 0", f4.deq_valid_o); end
      checks++; if (f4.enq_ready_o !== 1'b1) begin errors++; $display("FAIL single_pre_ready got %b want 1", f4.enq_ready_o); end
      tick();
      f4.enq_valid_i = 1'b0;
      #1;
      checks++; if (f4.deq_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", f4.deq_valid_o); end
      checks++; if (f4.deq_pc_o !== 32'h8000_0000) begin errors++; $display("FAIL single_pc got %h want 80000000", f4.deq_pc_o); end
      checks++; if (f4.deq_instr_o !== {32'h193, 32'h113, 32'h93, 32'h13}) begin errors++; $display("FAIL single_instr got %h", f4.deq_instr_o); end
      checks++; if (f4.deq_slot_valid_o !== 4'b1111) begin errors++; $display("FAIL single_slot_valid got %b want 1111", f4.deq_slot_valid_o); end
      checks++; if (f4.deq_pred_taken_o !== 4'b0100) begin errors++; $display("FAIL single_taken got %b want 0100", f4.deq_pred_taken_o); end
      checks++; if (f4.deq_pred_target_o !== 32'h8000_0040) begin errors++; $display("FAIL single_target got %h want 80000040", f4.deq_pred_target_o); end
      checks++; if (f4.count_o !== 3'd1) begin errors++; $display("FAIL single_count1 got %0d want 1", f4.count_o); end
      tick();
      checks++; if (f4.count_o !== 3'd0) begin errors++; $display("FAIL single_count0 got %0d want 0", f4.count_o); end
      checks++; if (f4.deq_valid_o !== 1'b0) begin errors++; $display("FAIL single_empty got %b want 0", f4.deq_valid_o); end
      f4.deq_ready_i = 1'b0;
   endtask

   task automatic test_full();
      logic [31:0] exp_pc;
      f4.deq_ready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         f4.enq_valid_i = 1'b1;
         f4.enq_pc_i    = 32'(k * 16);
         #1;
         checks++; if (f4.enq_ready_o !== 1'b1) begin errors++; $display("FAIL full_fill_ready k=%0d got %b want 1", k, f4.enq_ready_o); end
         tick();
      end
      f4.enq_pc_i = 32'h40;
      #1;
      checks++; if (f4.count_o !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", f4.count_o); end
      checks++; if (f4.enq_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", f4.enq_ready_o); end
      tick();
      checks++; if (f4.count_o !== 3'd4) begin errors++; $display("FAIL full_held got %0d want 4", f4.count_o); end
      f4.deq_ready_i = 1'b1;
      #1;
      checks++; if (f4.enq_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready_deq got %b want 0", f4.enq_ready_o); end
      checks++; if (f4.deq_pc_o !== 32'h0) begin errors++; $display("FAIL full_head got %h want 0", f4.deq_pc_o); end
      tick();
      f4.deq_ready_i = 1'b0;
      #1;
      checks++; if (f4.count_o !== 3'd3) begin errors++; $display("FAIL full_after_deq got %0d want 3", f4.count_o); end
      checks++; if (f4.enq_ready_o !== 1'b1) begin errors++; $display("FAIL full_freed got %b want 1", f4.enq_ready_o); end
      tick();
      f4.enq_valid_i = 1'b0;
      checks++; if (f4.count_o !== 3'd4) begin errors++; $display("FAIL full_refill got %0d want 4", f4.count_o); end
      f4.deq_ready_i = 1'b1;
      for (int k = 1; k < 5; k++) begin
         exp_pc = 32'(k * 16);
         #1;
         checks++; if (f4.deq_pc_o !== exp_pc) begin errors++; $display("FAIL full_order k=%0d got %h want %h", k, f4.deq_pc_o, exp_pc); end
         tick();
      end
      f4.deq_ready_i = 1'b0;
      checks++; if (f4.count_o !== 3'd0) begin errors++; $display("FAIL full_drained got %0d want 0", f4.count_o); end
   endtask

   task automatic test_back_to_back();
      tick();
      push4(32'h100);
      push4(32'h110);
      checks++; if (f4.count_o !== 3'd2) begin errors++; $display("FAIL b2b_pre got %0d want 2", f4.count_o); end
      f4.enq_valid_i = 1'b1;
      f4.enq_pc_i    = 32'h120;
      f4.deq_ready_i = 1'b1;
      #1;
      checks++; if (f4.deq_pc_o !== 32'h100) begin errors++; $display("FAIL b2b_head0 got %h want 100", f4.deq_pc_o); end
      tick();
      f4.enq_valid_i = 1'b0;
      f4.deq_ready_i = 1'b0;
      #1;
      checks++; if (f4.count_o !== 3'd2) begin errors++; $display("FAIL b2b_count got %0d want 2", f4.count_o); end
      checks++; if (f4.deq_pc_o !== 32'h110) begin errors++; $display("FAIL b2b_head1 got %h want 110", f4.deq_pc_o); end
      f4.deq_ready_i = 1'b1;
      tick();
      checks++; if (f4.deq_pc_o !== 32'h120) begin errors++; $display("FAIL b2b_head2 got %h want 120", f4.deq_pc_o); end
      tick();
      f4.deq_ready_i = 1'b0;
      checks++; if (f4.count_o !== 3'd0) begin errors++; $display("FAIL b2b_drained got %0d want 0", f4.count_o); end
   endtask

   task automatic test_flush();
      push4(32'h200);
      push4(32'h210);
      push4(32'h220);
      checks++; if (f4.count_o !== 3'd3) begin errors++; $display("FAIL flush_pre got %0d want 3", f4.count_o); end
      f4.flush_i     = 1'b1;
      f4.enq_valid_i = 1'b1;
      f4.enq_pc_i    = 32'h230;
      f4.deq_ready_i = 1'b1;
      #1;
      checks++; if (f4.enq_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", f4.enq_ready_o); end
      checks++; if (f4.deq_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", f4.deq_valid_o); end
      tick();
      f4.flush_i     = 1'b0;
      f4.enq_valid_i = 1'b0;
      f4.deq_ready_i = 1'b0;
      #1;
      checks++; if (f4.count_o !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", f4.count_o); end
      checks++; if (f4.deq_valid_o !== 1'b0) begin errors++; $display("FAIL flush_after_valid got %b want 0", f4.deq_valid_o); end
      checks++; if (f4.enq_ready_o !== 1'b1) begin errors++; $display("FAIL flush_after_ready got %b want 1", f4.enq_ready_o); end
      push4(32'h300);
      checks++; if (f4.deq_pc_o !== 32'h300) begin errors++; $display("FAIL flush_reuse got %h want 300", f4.deq_pc_o); end
      f4.deq_ready_i = 1'b1;
      tick();
      f4.deq_ready_i = 1'b0;
   endtask

   task automatic test_wrap();
      logic [31:0] vpat;
      logic [31:0] rpat;
      logic [31:0] exp_q[$];
      logic [31:0] pc;
      logic        v, r, ef, df;
      int          sent, rcvd, mcount, cyc;
      vpat = 32'hF7DF_BEFF;
      rpat = 32'hC3A5_0F01;
      sent = 0; rcvd = 0; mcount = 0; cyc = 0;
      while (rcvd < 10 && cyc < 64) begin
         v  = (sent < 10) && vpat[cyc % 32];
         r  = rpat[cyc % 32];
         pc = 32'h1000 + 32'(sent * 4);
         f3.enq_valid_i = v;
         f3.enq_pc_i    = pc;
         f3.deq_ready_i = r;
         #1;
         checks++; if (f3.count_o !== 2'(mcount)) begin errors++; $display("FAIL wrap_count cyc=%0d got %0d want %0d", cyc, f3.count_o, mcount); end
         checks++; if (f3.count_o > 2'd3) begin errors++; $display("FAIL wrap_bound cyc=%0d got %0d want <=3", cyc, f3.count_o); end
         checks++; if (f3.enq_ready_o !== (mcount != 3)) begin errors++; $display("FAIL wrap_ready cyc=%0d got %b want %b", cyc, f3.enq_ready_o, mcount != 3); end
         checks++; if (f3.deq_valid_o !== (mcount != 0)) begin errors++; $display("FAIL wrap_valid cyc=%0d got %b want %b", cyc, f3.deq_valid_o, mcount != 0); end
         ef = v && (mcount != 3);
         df = r && (mcount != 0);
         if (df) begin
            checks++; if (f3.deq_pc_o !== exp_q[0]) begin errors++; $display("FAIL wrap_order cyc=%0d got %h want %h", cyc, f3.deq_pc_o, exp_q[0]); end
            void'(exp_q.pop_front());
            rcvd++;
         end
         if (ef) begin
            exp_q.push_back(pc);
            sent++;
         end
         mcount = mcount + (ef ? 1 : 0) - (df ? 1 : 0);
         tick();
         cyc++;
      end
      f3.enq_valid_i = 1'b0;
      f3.deq_ready_i = 1'b0;
      checks++; if (rcvd != 10) begin errors++; $display("FAIL wrap_done got %0d want 10", rcvd); end
   endtask

   task automatic test_async_reset();
      push4(32'h400);
      push4(32'h410);
      checks++; if (f4.count_o !== 3'd2) begin errors++; $display("FAIL areset_pre got %0d want 2", f4.count_o); end
      #2 rst = 1'b1;
      #1;
      checks++; if (f4.count_o !== 3'd0) begin errors++; $display("FAIL areset_count got %0d want 0", f4.count_o); end
      checks++; if (f4.deq_valid_o !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", f4.deq_valid_o); end
      #1 rst = 1'b0;
      tick();
      checks++; if (f4.enq_ready_o !== 1'b1) begin errors++; $display("FAIL areset_ready got %b want 1", f4.enq_ready_o); end
      checks++; if (f4.count_o !== 3'd0) begin errors++; $display("FAIL areset_after got %0d want 0", f4.count_o); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_back_to_back();
      test_flush();
      test_wrap();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
